// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 8 data + odd parity + stop, device ACK check.
// Latency: INHIBIT_CYCLES + 1 clk, then paced by 11 device clock falls; completion pulse lands in the first IDLE cycle.
// Backpressure: tx_ready is high only in IDLE; tx_valid in any other state is ignored, nothing is queued.
//
// Ports:
//   clk, clrn               system clock, async active-low reset
//   ps2_clk, ps2_data       sensed open-drain lines (asynchronous to clk)
//   ps2_clk_oe, ps2_data_oe 1 = pull the line low, 0 = release
//   tx_data/tx_valid/tx_ready  byte request handshake
//   busy                    high outside IDLE
//   done/ack_err/timeout    one-cycle completion pulses, mutually exclusive
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [9:0]    frame;
  logic [3:0]    bit_idx;
  logic          data_oe_q;
  logic          ack_bit;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          fall;
  logic          clk_cur;
  logic          dat_cur;
  logic          watch;
  logic          expired;
  logic          finish;

  // Synchronizers reset to 1 (idle bus level) so no spurious fall follows reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign clk_cur = clk_sync[1];
  assign dat_cur = dat_sync[1];
  assign fall    = clk_sync[2] & ~clk_sync[1];

  // Timeout watch covers every state where the device owns the clock.
  assign watch   = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  // The counter would reach TIMEOUT_CYCLES on this edge unless a fall clears it.
  assign expired = watch && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign finish  = (state_q == S_WAIT_IDLE) && !expired && clk_cur && dat_cur;

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (tx_valid) state_d = S_INHIBIT;
      S_INHIBIT:   if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) state_d = S_REQ;
      S_REQ:       state_d = S_SEND;
      S_SEND: begin
        if (expired)                    state_d = S_IDLE;
        else if (fall && bit_idx == 4'd9) state_d = S_ACK;
      end
      S_ACK: begin
        if (expired)   state_d = S_IDLE;
        else if (fall) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (expired || finish) state_d = S_IDLE;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs: line drivers are decoded from state so reset releases them at once.
  always_comb begin
    tx_ready    = 1'b0;
    busy        = 1'b1;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
      S_INHIBIT: ps2_clk_oe = 1'b1;
      S_REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      S_SEND, S_ACK: ps2_data_oe = data_oe_q;
      default: ;
    endcase
  end

  // Datapath: frame, bit index, counters, ACK sample and completion pulses.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      frame     <= '0;
      bit_idx   <= '0;
      data_oe_q <= 1'b0;
      ack_bit   <= 1'b0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      done      <= 1'b0;
      ack_err   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done    <= finish & ~ack_bit;
      ack_err <= finish & ack_bit;
      timeout <= expired;

      if (state_q == S_IDLE && tx_valid)
        frame <= {1'b1, ~^tx_data, tx_data};

      if (state_q == S_INHIBIT) inh_cnt <= inh_cnt + IW'(1);
      else                      inh_cnt <= '0;

      if (watch && !fall) to_cnt <= to_cnt + TW'(1);
      else                to_cnt <= '0;

      case (state_q)
        S_REQ: begin
          bit_idx   <= '0;
          data_oe_q <= 1'b1;          // start bit stays low after the clock is released
        end
        S_SEND: if (fall) begin
          data_oe_q <= ~frame[bit_idx];
          bit_idx   <= bit_idx + 4'd1;
        end
        S_ACK: if (fall) ack_bit <= dat_cur;
        S_IDLE: begin
          bit_idx   <= '0;
          data_oe_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH = 8;
  localparam int TO  = 200;
  localparam int H   = 12;   // device half clock period in clk cycles

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk, ps2_data;
  logic       clk_oe, data_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, ack_err, timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Open-drain bus: low if either side pulls.
  assign ps2_clk  = ~(clk_oe | dev_clk_low);
  assign ps2_data = ~(data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout)
  );

  int total = 0;
  int bad = 0;
  int n_done = 0, n_err = 0, n_to = 0, n_acc = 0, n_multi = 0;
  int exp_done = 0, exp_err = 0, exp_to = 0, exp_acc = 0;
  logic busy_prev = 1'b0;
  logic [9:0] dev_rx;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Bus monitor: accepts seen as busy rising, pulse tallies, exclusivity.
  always @(negedge clk) begin
    if (busy && !busy_prev) n_acc++;
    busy_prev = busy;
    if (done)    n_done++;
    if (ack_err) n_err++;
    if (timeout) n_to++;
    if (int'(done) + int'(ack_err) + int'(timeout) > 1) n_multi++;
  end

  // Reference frame: data LSB first, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b};
  endfunction

  task automatic start_byte(input logic [7:0] b, input bit hold, input logic [7:0] held);
    int n;
    tx_data  = b;
    tx_valid = 1'b1;
    check("ready_before", tx_ready, 1);
    @(negedge clk);
    if (hold) tx_data = held;
    else      tx_valid = 1'b0;
    exp_acc++;
    check("accept_busy", busy, 1);
    check("ready_low", tx_ready, 0);
    n = 0;
    while (clk_oe && !data_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("req_clk_oe", clk_oe, 1);
    check("req_data_oe", data_oe, 1);
    @(negedge clk);
    check("send_clk_rel", clk_oe, 0);
    check("send_start", data_oe, 1);
  endtask

  task automatic dev_bits(input int n);
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      dev_rx[i] = ps2_data;
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic dev_ack(input bit ack_low);
    if (ack_low) dev_data_low = 1'b1;
    repeat (H / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  // kind: 1 done, 2 ack_err, 3 timeout, 0 none within budget
  task automatic wait_pulse(output int kind, output int lat);
    lat  = 0;
    kind = 0;
    while (!(done || ack_err || timeout) && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    if (done)         kind = 1;
    else if (ack_err) kind = 2;
    else if (timeout) kind = 3;
    check("end_ready", tx_ready, 1);
    check("end_clk_oe", clk_oe, 0);
    check("end_data_oe", data_oe, 0);
  endtask

  task automatic check_frame(input logic [7:0] b, input int n);
    logic [9:0] f;
    f = ref_frame(b);
    for (int i = 0; i < n; i++)
      check($sformatf("bit%0d_of_%02h", i, b), dev_rx[i], f[i]);
  endtask

  task automatic do_xfer(input logic [7:0] b, input bit ack_low, input bit hold, input logic [7:0] held);
    int kind, lat;
    start_byte(b, hold, held);
    dev_bits(10);
    check_frame(b, 10);
    dev_ack(ack_low);
    wait_pulse(kind, lat);
    check("xfer_kind", kind, ack_low ? 1 : 2);
    if (ack_low) exp_done++;
    else         exp_err++;
  endtask

  initial begin
    int kind, lat;
    int sd, se, st;
    logic [7:0] b;
    bit ackl;

    clrn     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pulses", int'(done) + int'(ack_err) + int'(timeout), 0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // Set-LEDs command with ACK.
    do_xfer(8'hED, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // Back-to-back: 0xFF requested in the cycle the 0x01 completion pulses.
    do_xfer(8'h01, 1'b1, 1'b0, 8'h00);
    do_xfer(8'hFF, 1'b1, 1'b0, 8'h00);
    check("par_01", ref_frame(8'h01) >> 8 & 10'h1, 0);
    check("par_ff_rx", dev_rx[8], 1);

    // Device NACK.
    repeat (3) @(negedge clk);
    do_xfer(8'hF4, 1'b0, 1'b0, 8'h00);

    // Device stops clocking after bit 3.
    repeat (3) @(negedge clk);
    start_byte(8'hA5, 1'b0, 8'h00);
    dev_bits(4);
    check_frame(8'hA5, 4);
    wait_pulse(kind, lat);
    exp_to++;
    check("to_kind", kind, 3);
    check("to_latency_ok", int'((lat + 2 * H) >= TO && (lat + 2 * H) <= TO + 6), 1);
    check("to_busy", busy, 0);

    // Reset while bit 5 (a 0) is on the line.
    repeat (3) @(negedge clk);
    start_byte(8'h0F, 1'b0, 8'h00);
    dev_bits(6);
    check("pre_rst_data_oe", data_oe, 1);
    #2;
    clrn = 1'b0;
    #1;
    check("async_clk_oe", clk_oe, 0);
    check("async_data_oe", data_oe, 0);
    check("async_ready", tx_ready, 1);
    @(negedge clk);
    clrn = 1'b1;
    sd = n_done; se = n_err; st = n_to;
    repeat (20) @(negedge clk);
    check("rst_no_pulse", (n_done - sd) + (n_err - se) + (n_to - st), 0);
    check("rst_ready_after", tx_ready, 1);

    // Hold tx_valid with a different byte through the whole transfer.
    do_xfer(8'h3C, 1'b1, 1'b1, 8'hC3);
    do_xfer(8'hC3, 1'b1, 1'b0, 8'h00);

    // Randomized bytes and ACK outcomes.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      b    = 8'($urandom_range(0, 255));
      ackl = ($urandom_range(0, 3) != 0);
      do_xfer(b, ackl, 1'b0, 8'h00);
    end

    repeat (5) @(negedge clk);
    check("total_accepts", n_acc, exp_acc);
    check("total_done", n_done, exp_done);
    check("total_ack_err", n_err, exp_err);
    check("total_timeout", n_to, exp_to);
    check("multi_pulse", n_multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard, such as 0xED (set LEDs) or 0xFF (reset), over the same open-drain ps2_clk/ps2_data pair that the keyboard receive path listens on. It performs the clock-inhibit / request-to-send sequence, shifts out data, odd parity and stop bit on device-generated clock edges, and checks the device ACK. It sits beside the receive path at keyboard level; the top level maps the *_oe outputs to tri-state pins.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles that ps2_clk is held low before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 1000000, max clk cycles allowed between device falling edges, or from release to the first edge (20 ms at 50 MHz).

Ports:
clk  in  1  system clock.
clrn  in  1  asynchronous active-low reset.
ps2_clk  in  1  sensed PS/2 clock line (asynchronous).
ps2_data  in  1  sensed PS/2 data line (asynchronous).
ps2_clk_oe  out  1  1 = pull ps2_clk low; 0 = release.
ps2_data_oe  out  1  1 = pull ps2_data low; 0 = release.
tx_data  in  8  byte to send.
tx_valid  in  1  request; accepted when tx_valid && tx_ready at a clk edge.
tx_ready  out  1  high only in IDLE.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse: transfer finished, device ACK = 0.
ack_err  out  1  one-cycle pulse: transfer finished, ACK bit sampled 1.
timeout  out  1  one-cycle pulse: transfer aborted on timeout.

Behaviour:
- Reset (async, clrn=0): state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done/ack_err/timeout=0, all counters 0. Reset mid-transfer releases both lines immediately.
- Input sync: ps2_clk uses a 3-flop synchronizer and ps2_data a 2-flop synchronizer. fall = (previous synced clk == 1) && (current == 0). All edge logic uses synced values only.
- Accept: in IDLE, tx_valid && tx_ready latches frame = {1'b1 stop, ~^tx_data parity (odd), tx_data}. Go to INHIBIT. tx_valid outside IDLE is ignored.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles. Then go to REQ.
- REQ (1 cycle): ps2_clk_oe=1, ps2_data_oe=1 (start bit). Then go to SEND with ps2_clk_oe=0 and ps2_data_oe held 1. The timeout counter clears.
- SEND: bit index n = 0..9 (d0..d7 LSB first, parity, stop). On each fall, ps2_data_oe <= ~frame[n] and n increments. After the fall that places the stop bit (n=9, line released), go to ACK.
- ACK: on the next fall, sample synced ps2_data into ack_bit. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synced ps2_clk==1 && ps2_data==1. Then pulse done (ack_bit==0) or ack_err (ack_bit==1) for 1 cycle and return to IDLE; tx_ready rises that same cycle.
- Timeout: in SEND/ACK/WAIT_IDLE a counter increments each cycle and clears on every fall. When it reaches TIMEOUT_CYCLES, both lines release, timeout pulses 1 cycle, and the state returns to IDLE. done and ack_err are not asserted.
- Pulses are mutually exclusive; exactly one of done/ack_err/timeout fires per accepted byte.
- Frame generation never drives a line high; only *_oe=1 pulls low.
- Back-to-back: a new tx_valid may be accepted in the cycle after the completion pulse.

Test Plan:
1. INHIBIT_CYCLES=8. Send 0xED; device model clocks at 10 kHz-equivalent and ACKs low. Required: clk_oe low for exactly 8 cycles, then REQ. Device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1. done pulses once; tx_ready returns to 1.
2. Send 0x01, then 0xFF. Required: parity bits sampled as 0 and 1 respectively. Second byte accepted in the cycle after the first done.
3. Device model leaves data high in the ACK slot. Required: ack_err pulses once, done stays 0, both oe=0.
4. TIMEOUT_CYCLES=200; device stops clocking after bit 3. Required: 200 cycles after the last fall, timeout pulses, ps2_data_oe=0, state IDLE.
5. Assert clrn=0 during SEND at bit 5. Required: ps2_clk_oe and ps2_data_oe go 0 asynchronously. After release, tx_ready=1 and no pulse fires.
6. Hold tx_valid high with a new byte throughout a transfer. Required: exactly one accept per IDLE visit; the held byte is not latched mid-frame.
